// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA constants, pixel address type and arbiter FSM states.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int PIX_W    = 12;
  typedef logic [18:0] pix_addr_t;
  typedef enum logic [1:0] {SCAN, GUARD, WRITE} arb_state_t;
endpackage

// File: rtl/vram_wfifo.sv
// vram_wfifo: synchronous DEPTH x W write-request FIFO with registered level.
// Ports: vga_clk/clrn clock and async active-low reset; push/din enqueue;
// pop dequeues the head shown on dout; full, empty and level report occupancy.
module vram_wfifo #(
  parameter int DEPTH = 8,
  parameter int W     = 31
) (
  input  logic                     vga_clk,
  input  logic                     clrn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          push_ok, pop_ok;
  assign full    = level == LW'(DEPTH);
  assign empty   = level == '0;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rptr];
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok) rptr <= rptr + 1'b1;
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
  end
  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge vga_clk) begin
    if (push_ok) mem[wptr] <= din;
  end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the pixel RAM between vgac scan-out (priority) and a buffered writer.
// Ports: vga_clk/clrn clock and async active-low reset; rdn/row_addr/col_addr from vgac;
// wr_valid/wr_ready/wr_addr/wr_data writer handshake; ram_addr/ram_we/ram_wdata RAM pins;
// fifo_level and busy report queued writes.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 19,
  parameter int DW    = 12
) (
  input  logic                   vga_clk,
  input  logic                   clrn,
  input  logic                   rdn,
  input  logic [8:0]             row_addr,
  input  logic [9:0]             col_addr,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [AW-1:0]          wr_addr,
  input  logic [DW-1:0]          wr_data,
  output logic [AW-1:0]          ram_addr,
  output logic                   ram_we,
  output logic [DW-1:0]          ram_wdata,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   busy
);
  arb_state_t        state;
  pix_addr_t         scan_addr;
  logic [AW+DW-1:0]  head;
  logic              full, empty;
  vram_wfifo #(.DEPTH(DEPTH), .W(AW + DW)) u_fifo (
    .vga_clk (vga_clk),
    .clrn    (clrn),
    .push    (wr_valid && wr_ready),
    .pop     (ram_we),
    .din     ({wr_addr, wr_data}),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );
  assign wr_ready  = !full;
  assign busy      = !empty;
  assign scan_addr = {row_addr, col_addr};
  // rdn gates the write combinationally so a read cycle never sees a write,
  // even in the cycle before the FSM returns to SCAN.
  assign ram_we    = state == WRITE && !empty && rdn;
  assign ram_addr  = ram_we ? head[AW+DW-1:DW] : AW'(scan_addr);
  assign ram_wdata = ram_we ? head[DW-1:0] : '0;
  // GUARD gives one idle turnaround cycle after every scan-to-blank edge.
  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) state <= SCAN;
    else state <= !rdn ? SCAN : (state == SCAN ? GUARD : WRITE);
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed and randomized-frame checks of vram_arbiter.
module tb_vram_arbiter;
  logic        vga_clk = 1'b0;
  logic        clrn, rdn, wr_valid, wr_ready, ram_we, busy;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic [18:0] wr_addr, ram_addr;
  logic [11:0] wr_data, ram_wdata;
  logic [3:0]  fifo_level;
  int passed = 0, total = 0;
  logic        mon_en = 1'b0;
  int          viol = 0, bad = 0, nw = 0, np = 0;
  logic [30:0] exp_q [$];
  logic [30:0] e;

  vram_arbiter dut (
    .vga_clk(vga_clk), .clrn(clrn), .rdn(rdn), .row_addr(row_addr), .col_addr(col_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .fifo_level(fifo_level), .busy(busy)
  );

  always #5 vga_clk = ~vga_clk;

  always @(negedge vga_clk) begin
    if (mon_en) begin
      if (ram_we && !rdn) viol++;
      if (ram_we) begin
        nw++;
        if (exp_q.size() == 0) bad++;
        else begin
          e = exp_q.pop_front();
          if ({ram_addr, ram_wdata} !== e) bad++;
        end
      end
      if (wr_valid && wr_ready) begin
        np++;
        exp_q.push_back({wr_addr, wr_data});
      end
    end
  end

  task automatic clk1;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic push_one(input logic [18:0] a, input logic [11:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    clk1();
    wr_valid = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    @(negedge vga_clk);
    total++; if (ram_we !== 1'b0) $display("FAIL reset_we: got %b want 0", ram_we); else passed++;
    total++; if (fifo_level !== 4'd0) $display("FAIL reset_level: got %0d want 0", fifo_level); else passed++;
    total++; if (wr_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_flags: ready %b busy %b want 1 0", wr_ready, busy); else passed++;
    total++; if (ram_addr !== 19'h00C07 || ram_wdata !== 12'h000) $display("FAIL reset_port: addr %h data %h want 00c07 000", ram_addr, ram_wdata); else passed++;
    clk1();
    clrn = 1'b1;
    clk1();
    for (int i = 0; i < 5; i++) push_one(19'h00010 + 19'(i), 12'h010 + 12'(i));
    @(negedge vga_clk);
    total++; if (fifo_level !== 4'd5) $display("FAIL mid_level: got %0d want 5", fifo_level); else passed++;
    rdn = 1'b1;
    clk1();
    clrn = 1'b0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge vga_clk);
      if (ram_we) n++;
      clk1();
    end
    @(negedge vga_clk);
    total++; if (n !== 0) $display("FAIL mid_reset_we: got %0d writes want 0", n); else passed++;
    total++; if (fifo_level !== 4'd0) $display("FAIL mid_reset_level: got %0d want 0", fifo_level); else passed++;
    clrn = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      clk1();
      @(negedge vga_clk);
      if (ram_we) n++;
    end
    total++; if (n !== 0) $display("FAIL post_reset_we: got %0d writes want 0", n); else passed++;
    total++; if (fifo_level !== 4'd0 || wr_ready !== 1'b1) $display("FAIL post_reset_state: level %0d ready %b want 0 1", fifo_level, wr_ready); else passed++;
    rdn = 1'b0;
    clk1();
  endtask

  task automatic test_single;
    push_one(19'h00A05, 12'hF00);
    @(negedge vga_clk);
    total++; if (ram_we !== 1'b0 || fifo_level !== 4'd1) $display("FAIL single_hold: we %b level %0d want 0 1", ram_we, fifo_level); else passed++;
    clk1();
    rdn = 1'b1;
    @(negedge vga_clk);
    total++; if (ram_we !== 1'b0) $display("FAIL single_t0: we %b want 0", ram_we); else passed++;
    clk1();
    @(negedge vga_clk);
    total++; if (ram_we !== 1'b0) $display("FAIL single_guard: we %b want 0", ram_we); else passed++;
    clk1();
    @(negedge vga_clk);
    total++; if (ram_we !== 1'b1 || ram_addr !== 19'h00A05 || ram_wdata !== 12'hF00) $display("FAIL single_write: we %b addr %h data %h want 1 00a05 f00", ram_we, ram_addr, ram_wdata); else passed++;
    clk1();
    @(negedge vga_clk);
    total++; if (fifo_level !== 4'd0 || busy !== 1'b0 || ram_we !== 1'b0) $display("FAIL single_done: level %0d busy %b we %b want 0 0 0", fifo_level, busy, ram_we); else passed++;
    rdn = 1'b0;
    clk1();
  endtask

  task automatic test_full;
    for (int i = 0; i < 8; i++) push_one(19'h00100 + 19'(i), 12'h100 + 12'(i));
    @(negedge vga_clk);
    total++; if (wr_ready !== 1'b0 || fifo_level !== 4'd8) $display("FAIL full_flag: ready %b level %0d want 0 8", wr_ready, fifo_level); else passed++;
    wr_valid = 1'b1;
    wr_addr  = 19'h001FF;
    wr_data  = 12'hABC;
    clk1();
    rdn = 1'b1;
    @(negedge vga_clk);
    total++; if (fifo_level !== 4'd8 || ram_we !== 1'b0) $display("FAIL full_hold: level %0d we %b want 8 0", fifo_level, ram_we); else passed++;
    clk1();
    clk1();
    @(negedge vga_clk);
    total++; if (ram_we !== 1'b1 || ram_addr !== 19'h00100 || wr_ready !== 1'b0) $display("FAIL full_first_pop: we %b addr %h ready %b want 1 00100 0", ram_we, ram_addr, wr_ready); else passed++;
    clk1();
    @(negedge vga_clk);
    total++; if (fifo_level !== 4'd7 || wr_ready !== 1'b1 || ram_addr !== 19'h00101) $display("FAIL full_accept: level %0d ready %b addr %h want 7 1 00101", fifo_level, wr_ready, ram_addr); else passed++;
    clk1();
    wr_valid = 1'b0;
    @(negedge vga_clk);
    total++; if (fifo_level !== 4'd7 || ram_addr !== 19'h00102) $display("FAIL full_pushpop: level %0d addr %h want 7 00102", fifo_level, ram_addr); else passed++;
    for (int i = 3; i < 8; i++) begin
      clk1();
      @(negedge vga_clk);
      total++; if (ram_we !== 1'b1 || ram_addr !== 19'h00100 + 19'(i) || ram_wdata !== 12'h100 + 12'(i)) $display("FAIL full_drain%0d: we %b addr %h data %h", i, ram_we, ram_addr, ram_wdata); else passed++;
    end
    clk1();
    @(negedge vga_clk);
    total++; if (ram_we !== 1'b1 || ram_addr !== 19'h001FF || ram_wdata !== 12'hABC) $display("FAIL full_ninth: we %b addr %h data %h want 1 001ff abc", ram_we, ram_addr, ram_wdata); else passed++;
    clk1();
    @(negedge vga_clk);
    total++; if (fifo_level !== 4'd0 || ram_we !== 1'b0) $display("FAIL full_empty: level %0d we %b want 0 0", fifo_level, ram_we); else passed++;
    rdn = 1'b0;
    clk1();
  endtask

  task automatic test_blank_end;
    logic [18:0] got [2];
    int n;
    for (int i = 0; i < 6; i++) push_one(19'h00200 + 19'(i), 12'h0A0 + 12'(i));
    rdn = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge vga_clk);
      if (ram_we) begin
        if (n < 2) got[n] = ram_addr;
        n++;
      end
      clk1();
    end
    rdn = 1'b0;
    row_addr = 9'd5;
    col_addr = 10'd9;
    @(negedge vga_clk);
    total++; if (ram_we !== 1'b0 || ram_addr !== 19'h01409) $display("FAIL blank_fall: we %b addr %h want 0 01409", ram_we, ram_addr); else passed++;
    total++; if (n !== 2) $display("FAIL blank_count: got %0d writes want 2", n); else passed++;
    total++; if (got[0] !== 19'h00200 || got[1] !== 19'h00201) $display("FAIL blank_order: got %h %h want 00200 00201", got[0], got[1]); else passed++;
    clk1();
    col_addr = 10'd10;
    @(negedge vga_clk);
    total++; if (fifo_level !== 4'd4 || ram_addr !== 19'h0140A || ram_we !== 1'b0) $display("FAIL blank_after: level %0d addr %h we %b want 4 0140a 0", fifo_level, ram_addr, ram_we); else passed++;
    clk1();
  endtask

  task automatic test_simul;
    rdn = 1'b1;
    clk1();
    clk1();
    @(negedge vga_clk);
    total++; if (ram_we !== 1'b1 || ram_addr !== 19'h00202) $display("FAIL simul_first: we %b addr %h want 1 00202", ram_we, ram_addr); else passed++;
    clk1();
    wr_valid = 1'b1;
    wr_addr  = 19'h00300;
    wr_data  = 12'h3AA;
    @(negedge vga_clk);
    total++; if (fifo_level !== 4'd3 || ram_addr !== 19'h00203) $display("FAIL simul_pre: level %0d addr %h want 3 00203", fifo_level, ram_addr); else passed++;
    clk1();
    wr_valid = 1'b0;
    @(negedge vga_clk);
    total++; if (fifo_level !== 4'd3 || ram_addr !== 19'h00204) $display("FAIL simul_level: level %0d addr %h want 3 00204", fifo_level, ram_addr); else passed++;
    clk1();
    @(negedge vga_clk);
    total++; if (ram_we !== 1'b1 || ram_addr !== 19'h00205 || ram_wdata !== 12'h0A5) $display("FAIL simul_old: we %b addr %h data %h want 1 00205 0a5", ram_we, ram_addr, ram_wdata); else passed++;
    clk1();
    @(negedge vga_clk);
    total++; if (ram_we !== 1'b1 || ram_addr !== 19'h00300 || ram_wdata !== 12'h3AA) $display("FAIL simul_new: we %b addr %h data %h want 1 00300 3aa", ram_we, ram_addr, ram_wdata); else passed++;
    clk1();
    @(negedge vga_clk);
    total++; if (fifo_level !== 4'd0 || ram_we !== 1'b0) $display("FAIL simul_empty: level %0d we %b want 0 0", fifo_level, ram_we); else passed++;
    rdn = 1'b0;
    clk1();
  endtask

  task automatic test_frame;
    mon_en = 1'b1;
    for (int line = 0; line < 12; line++) begin
      for (int c = 0; c < 800; c++) begin
        rdn      = c >= 640;
        row_addr = 9'(line);
        col_addr = c < 640 ? 10'(c) : 10'd0;
        wr_valid = $urandom_range(0, 2) != 0;
        wr_addr  = 19'($urandom);
        wr_data  = 12'($urandom);
        clk1();
      end
    end
    for (int c = 0; c < 300; c++) begin
      rdn      = 1'b1;
      row_addr = 9'd480;
      wr_valid = $urandom_range(0, 2) != 0;
      wr_addr  = 19'($urandom);
      wr_data  = 12'($urandom);
      clk1();
    end
    wr_valid = 1'b0;
    for (int c = 0; c < 20; c++) clk1();
    mon_en = 1'b0;
    total++; if (viol !== 0) $display("FAIL frame_we_on_read: got %0d cycles want 0", viol); else passed++;
    total++; if (bad !== 0) $display("FAIL frame_order: got %0d bad writes want 0", bad); else passed++;
    total++; if (nw !== np || exp_q.size() !== 0) $display("FAIL frame_count: writes %0d pushes %0d left %0d", nw, np, exp_q.size()); else passed++;
    total++; if (np < 100) $display("FAIL frame_traffic: got %0d pushes want >= 100", np); else passed++;
    rdn = 1'b0;
    clk1();
  endtask

  initial begin
    clrn     = 1'b0;
    rdn      = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    row_addr = 9'd3;
    col_addr = 10'd7;
    test_reset();
    test_single();
    test_full();
    test_blank_end();
    test_simul();
    test_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Arbitrates the single-port 640x480 pixel RAM between the `vgac` scan-out reader and one pixel writer, such as a CPU or drawing engine. Scan-out always has priority. Writer requests are buffered in a small FIFO and drained only while `vgac` reports no pixel read (`rdn` high), so the display never sees a read stall. It sits between `vgac`, the writer and the pixel RAM, and owns the RAM address, write-enable and write-data pins.

## Interface
Parameters:
- DEPTH, 8, write FIFO entries; power of two, at least 2.
- AW, 19, RAM address width: {row[8:0], col[9:0]}.
- DW, 12, pixel width, bbbb_gggg_rrrr.

Ports:
- vga_clk  in  1  pixel clock, 25 MHz.
- clrn  in  1  asynchronous reset, active-low.
- rdn  in  1  `vgac` pixel-read request, active-low.
- row_addr  in  9  `vgac` row address.
- col_addr  in  10  `vgac` column address.
- wr_valid  in  1  writer request valid.
- wr_ready  out  1  FIFO can accept a request.
- wr_addr  in  AW  writer pixel address.
- wr_data  in  DW  writer pixel data.
- ram_addr  out  AW  RAM address.
- ram_we  out  1  RAM write enable, active-high.
- ram_wdata  out  DW  RAM write data.
- fifo_level  out  clog2(DEPTH)+1  number of occupied FIFO entries.
- busy  out  1  FIFO non-empty.

## Operation
- Reset is clrn asynchronous, active-low; the clock is vga_clk.
- FIFO behaviour:
  - A push occurs on a cycle with wr_valid && wr_ready.
  - wr_ready = !full; there is no pass-through when full, even if a pop happens in the same cycle.
  - Simultaneous push and pop leaves the level unchanged. Order is strictly FIFO.
- FSM states are SCAN, GUARD and WRITE.
  - SCAN: ram_addr = {row_addr, col_addr} and ram_we = 0. Go to GUARD when rdn = 1.
  - GUARD: one idle cycle with no write, giving RAM turnaround margin. ram_addr keeps the scan address and ram_we = 0. Go to SCAN if rdn = 0, otherwise to WRITE.
  - WRITE: ram_we = !empty && rdn, with ram_addr/ram_wdata taken from the FIFO head. A pop occurs when ram_we = 1. Go to SCAN if rdn = 0, otherwise stay in WRITE.
- The rdn gate on ram_we is combinational. A write is therefore never issued in a cycle where rdn = 0, even before the FSM leaves WRITE.
- When not writing, ram_addr = {row_addr, col_addr} in every state. This keeps the RAM output valid for `vgac` at the first read cycle.
- Width rules:
  - fifo_level counts 0..DEPTH.
  - Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
  - Addresses pass through unchecked; writes to row >= 480 or col >= 640 are performed as given.
- Reset:
  - Values: state = SCAN, pointers = 0, fifo_level = 0, busy = 0, wr_ready = 1, ram_we = 0.
  - ram_addr follows the `vgac` inputs; ram_wdata = 0.
  - Reset mid-operation discards all queued writes, and no partial write is issued.

## Timing
- The RAM port is combinational from the registered FSM state, the FIFO head and rdn. It is used with an asynchronous-read RAM, and `vgac` registers the returned data.
- FSM decisions use rdn as registered by `vgac`.
- Push to write latency: a push in cycle t makes the entry visible at t+1. The earliest write is t+1, and only if the FSM is in WRITE and rdn = 1.
- Blanking turnaround:
  - rdn rises in cycle t: GUARD at t+1, first write at t+2.
  - rdn falls in cycle t: ram_we = 0 at t, SCAN at t+1.
- Capacity:
  - Each line has 160 non-read cycles, which allows up to 158 writes per horizontal blank.
  - Vertical blank allows sustained 1 write per cycle.
- fifo_level and busy are registered and update the cycle after a push or pop.

## Structure
- Shared package `vga_pkg`:
  - Constants H_ACTIVE=640, V_ACTIVE=480 and PIX_W=12.
  - Typedef pix_addr_t (19 bits, {row, col}).
  - Enum arb_state_t {SCAN, GUARD, WRITE}.
- One sub-module, `vram_wfifo`: a synchronous DEPTH x (AW+DW) FIFO with full, empty and level outputs. The arbiter FSM and the RAM port mux stay in `vram_arbiter`.

## Test plan
1. Reset mid-stream: assert clrn=0 with fifo_level=5 and rdn=1.
   - While asserted: ram_we=0.
   - After release: fifo_level=0, wr_ready=1, no write issued.
2. Single write during active video: rdn=0, push addr 0x0_0A05, data 0xF00.
   - No ram_we while rdn=0.
   - rdn rises at t; ram_we=1 at t+2 with ram_addr=0x0_0A05 and ram_wdata=0xF00.
   - fifo_level becomes 0.
3. Full FIFO: push 8 entries while rdn=0.
   - wr_ready=0 after the 8th push.
   - A 9th push held on wr_valid is accepted only after the first blank-cycle pop.
4. Blank ends mid-drain: 6 entries queued, rdn=1 for 4 cycles, then 0.
   - Exactly 2 writes, in order.
   - ram_we=0 in the rdn-fall cycle; fifo_level=4.
   - ram_addr equals {row_addr, col_addr} for the next cycles.
5. Simultaneous push and pop in WRITE at level 3.
   - fifo_level stays 3 and write order is preserved.
6. Full frame with random writer traffic against the `vgac` timing.
   - Never ram_we && !rdn.
   - Every accepted write lands exactly once, in order.
